// File: rtl/ecc_pkg.sv
// Shared types and register field positions for the ECC operation sequencer.
package ecc_pkg;

    typedef enum logic [1:0] {
        OP_ENC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_FULL = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        W8   = 2'd0,
        W16  = 2'd1,
        W32  = 2'd2,
        WINV = 2'd3
    } cw_width_e;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StEncRun,
        StDecRun,
        StDone,
        StErr
    } seq_state_e;

    localparam int unsigned CtrlOpLsb  = 0;
    localparam int unsigned CtrlOpMsb  = 1;
    localparam int unsigned WidthLsb   = 0;
    localparam int unsigned WidthMsb   = 1;

    function automatic logic cfg_invalid(input op_e op, input cw_width_e width);
        return (op == OP_RSVD) || (width == WINV);
    endfunction

endpackage

// File: rtl/ecc_phase_timer.sv
// Per-phase cycle counter; the count is zero in the cycle after a restart.
module ecc_phase_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] count_d, count_q;

    assign expired_o = (count_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ecc_op_sequencer.sv
// Snapshots the ECC configuration on a CTRL write, runs encoder/decoder phases and
// reports completion, error count and sticky error flags.
module ecc_op_sequencer
    import ecc_pkg::*;
#(
    parameter int unsigned AMBA_WORD      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 CTRL_ready,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic                 enc_done,
    input  logic                 dec_done,
    input  logic [1:0]           dec_num_of_errors,
    output logic                 enc_start,
    output logic                 dec_start,
    output logic                 noise_en,
    output logic [1:0]           op_mode,
    output logic [1:0]           cw_width_sel,
    output logic                 busy,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors,
    output logic                 err_cfg,
    output logic                 err_timeout,
    output logic                 overrun
);

    seq_state_e state_d, state_q;
    op_e        op_d, op_q;
    cw_width_e  width_d, width_q;
    logic       enc_start_d, enc_start_q;
    logic       dec_start_d, dec_start_q;
    logic       noise_d, noise_q;
    logic       busy_d, busy_q;
    logic       done_d, done_q;
    logic [1:0] nerr_d, nerr_q;
    logic       err_cfg_d, err_cfg_q;
    logic       err_to_d, err_to_q;
    logic       overrun_d, overrun_q;
    logic       timer_restart;
    logic       timer_expired;

    // Only the low fields of the register words are meaningful.
    logic unused_reg_bits;
    assign unused_reg_bits = ^{CTRL[AMBA_WORD-1:CtrlOpMsb+1],
                               CODEWORD_WIDTH[AMBA_WORD-1:WidthMsb+1]};

    ecc_phase_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .restart_i(timer_restart),
        .enable_i ((state_q == StEncRun) || (state_q == StDecRun)),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        width_d       = width_q;
        enc_start_d   = 1'b0;
        dec_start_d   = 1'b0;
        noise_d       = noise_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        nerr_d        = nerr_q;
        err_cfg_d     = err_cfg_q;
        err_to_d      = err_to_q;
        overrun_d     = overrun_q;
        timer_restart = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (CTRL_ready) begin
                    op_d      = op_e'(CTRL[CtrlOpMsb:CtrlOpLsb]);
                    width_d   = cw_width_e'(CODEWORD_WIDTH[WidthMsb:WidthLsb]);
                    nerr_d    = 2'd0;
                    err_cfg_d = 1'b0;
                    err_to_d  = 1'b0;
                    overrun_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                if (cfg_invalid(op_q, width_q)) begin
                    err_cfg_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StErr;
                end else if (op_q == OP_DEC) begin
                    dec_start_d   = 1'b1;
                    timer_restart = 1'b1;
                    state_d       = StDecRun;
                end else begin
                    enc_start_d   = 1'b1;
                    noise_d       = (op_q == OP_FULL);
                    timer_restart = 1'b1;
                    state_d       = StEncRun;
                end
            end
            StEncRun: begin
                // The entry cycle is marked by enc_start_q; a done there is ignored.
                if (enc_done && !enc_start_q) begin
                    noise_d = 1'b0;
                    if (op_q == OP_FULL) begin
                        dec_start_d   = 1'b1;
                        timer_restart = 1'b1;
                        state_d       = StDecRun;
                    end else begin
                        nerr_d  = 2'd0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end else if (timer_expired) begin
                    noise_d  = 1'b0;
                    err_to_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = StErr;
                end
            end
            StDecRun: begin
                if (dec_done) begin
                    nerr_d  = dec_num_of_errors;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (timer_expired) begin
                    err_to_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = StErr;
                end
            end
            StDone, StErr: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                noise_d = 1'b0;
                state_d = StIdle;
            end
        endcase

        if (CTRL_ready && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= OP_ENC;
            width_q     <= W8;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            noise_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            nerr_q      <= 2'd0;
            err_cfg_q   <= 1'b0;
            err_to_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            width_q     <= width_d;
            enc_start_q <= enc_start_d;
            dec_start_q <= dec_start_d;
            noise_q     <= noise_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            nerr_q      <= nerr_d;
            err_cfg_q   <= err_cfg_d;
            err_to_q    <= err_to_d;
            overrun_q   <= overrun_d;
        end
    end

    assign enc_start      = enc_start_q;
    assign dec_start      = dec_start_q;
    assign noise_en       = noise_q;
    assign op_mode        = op_q;
    assign cw_width_sel   = width_q;
    assign busy           = busy_q;
    assign operation_done = done_q;
    assign num_of_errors  = nerr_q;
    assign err_cfg        = err_cfg_q;
    assign err_timeout    = err_to_q;
    assign overrun        = overrun_q;

endmodule
